pkt_mux: RTL and testbench
==========================

// Module: pkt_mux
// PURPOSE
//  Merges the PGM, LCM and SSM return streams into the single 134-bit packet stream toward the FPGA OS.
//  Sits opposite the ingress demux, as its egress counterpart.
//  Each source writes into its own packet FIFO; a packet-level round-robin arbiter emits whole packets.
//  Word tag [133:132]: 01=head, 11=body, 10=tail.
// PARAMETERS
//  DATA_AW      8    log2 data-FIFO depth per source (256 x 134b)
//  VALID_AW     4    log2 valid-flag FIFO depth per source (16 x 1b)
//  READY_FREE   100  min free data words for <src>2mux_data_ready=1 (>= max packet 96 words + 4)
// PORTS
//  clk                     in   1    sole clock
//  rst                     in   1    synchronous, active-high reset
//  {pgm,lcm,ssm}2mux_data        in   134  source packet word
//  {pgm,lcm,ssm}2mux_data_wr     in   1    word write strobe
//  {pgm,lcm,ssm}2mux_data_valid  in   1    packet-valid flag (1=forward, 0=discard)
//  {pgm,lcm,ssm}2mux_data_valid_wr in 1    valid-flag strobe, once per packet, with or after tail
//  mux2{pgm,lcm,ssm}_data_ready  out  1    source may start a new packet
//  pktout_data             out  134  merged word toward the FPGA OS
//  pktout_data_wr          out  1    word strobe
//  pktout_data_valid       out  1    always 1 when strobed (discarded packets are never emitted)
//  pktout_data_valid_wr    out  1    pulses with the tail word
//  pktout_data_ready       in   1    downstream can accept a whole packet
//  mux_err                 out  3    sticky overflow flags {ssm,lcm,pgm}
// BEHAVIOUR
//  Reset: all outputs 0, except ready=1 one cycle after reset deasserts. FIFOs empty, rr pointer=PGM, state IDLE.
//  Write side: data_wr pushes a word; valid_wr pushes the flag.
//   - A push to a full FIFO drops the word and sets mux_err[src]. The flag stays set until rst.
//   - ready = (free data words >= READY_FREE) && !valid FIFO full; registered.
//  Read FSM: IDLE -> SEND | DROP -> IDLE.
//   IDLE: eligible src = valid FIFO non-empty.
//    - If pktout_data_ready=1 and any source is eligible, grant rr order starting after the last granted source.
//    - Pop the flag. Flag=1 -> SEND, flag=0 -> DROP.
//    - With no downstream ready, a flag=0 packet may still be granted (DROP needs no ready).
//   SEND: one word per cycle, no bubbles, pktout_data_ready ignored mid-packet.
//    - On the tail word: pktout_data_valid=1 and valid_wr=1, then IDLE.
//   DROP: pop words with no output strobes until the tail, then IDLE.
//   Latency: head word appears on pktout 2 cycles after the IDLE grant cycle.
//   Back-to-back packets have at most 2 idle cycles between tail and next head.
//  Boundaries:
//   - Simultaneous push/pop on the same FIFO is legal; the count stays unchanged.
//   - A flag whose data has not fully arrived never happens; the tail precedes or coincides with valid_wr.
//   - rst mid-packet truncates the output immediately. All FIFOs flush and no partial tail is generated.
//   - A head word missing its 01 tag is forwarded verbatim; the tag is only checked for the tail (10).
// CONFIGURATION
//  `MUX_LCM_PRIO_EN defined: LCM has strict priority in IDLE over the rr among PGM/SSM.
//    The rr pointer skips LCM and only advances on PGM/SSM grants.
//  Undefined: plain 3-way round-robin.
// STRUCTURE
//  pkt_mux_pkg: localparams for tags HEAD=2'b01, BODY=2'b11, TAIL=2'b10.
//   Also source indices PGM=0, LCM=1, SSM=2, and the FSM state encoding IDLE/SEND/DROP.
//  Sub-module pkt_mux_fifo, instanced 3x:
//   - data FIFO + valid FIFO
//   - free-count and ready logic
//   - overflow flag
//   - registered read data
// TESTING
//  1. PGM sends a 4-word packet with flag=1, ready=1:
//     -> pktout shows 01,11,11,10 on 4 consecutive cycles, valid_wr on word 4 only.
//  2. LCM packet with flag=0, then SSM packet with flag=1:
//     -> only the SSM words appear; LCM data FIFO returns to empty.
//  3. All three sources hold one 2-word packet, ready=1:
//     -> output order PGM,LCM,SSM. With `MUX_LCM_PRIO_EN, LCM goes first.
//  4. pktout_data_ready=0 with 3 pending packets:
//     -> no strobes. Drop ready mid-packet -> the packet still completes.
//  5. Push 157 words into PGM without reading:
//     -> mux2pgm_data_ready falls when free reaches 99. The 257th word sets mux_err[0].
//  6. Assert rst during word 2 of a 5-word send:
//     -> next cycle all outputs 0, no tail emitted, FIFOs empty.

Source files
------------

// File: rtl/pkt_mux_pkg.sv
// Shared constants for the egress packet mux: word tags, source indices and read-FSM states.
package pkt_mux_pkg;
    localparam int WORD_W = 134;

    localparam logic [1:0] HEAD = 2'b01;
    localparam logic [1:0] BODY = 2'b11;
    localparam logic [1:0] TAIL = 2'b10;

    localparam logic [1:0] PGM = 2'd0;
    localparam logic [1:0] LCM = 2'd1;
    localparam logic [1:0] SSM = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DROP = 2'd2
    } mux_state_t;

    function automatic logic [1:0] next_src(input logic [1:0] s);
        return (s == SSM) ? PGM : s + 2'd1;
    endfunction
endpackage

// File: rtl/pkt_mux_if.sv
// Source-side and egress-side signals of pkt_mux; slave = the mux, master = its environment.
// Write side: a word is taken whenever <src>2mux_data_wr=1 (no back-pressure per word); a source
// only starts a packet while mux2<src>_data_ready=1. Egress: a packet starts only while
// pktout_data_ready=1 and then streams one word per cycle to its tail.
interface pkt_mux_if;
    import pkt_mux_pkg::*;

    logic [WORD_W-1:0] pgm2mux_data, lcm2mux_data, ssm2mux_data;
    logic pgm2mux_data_wr, lcm2mux_data_wr, ssm2mux_data_wr;
    logic pgm2mux_data_valid, lcm2mux_data_valid, ssm2mux_data_valid;
    logic pgm2mux_data_valid_wr, lcm2mux_data_valid_wr, ssm2mux_data_valid_wr;
    logic mux2pgm_data_ready, mux2lcm_data_ready, mux2ssm_data_ready;
    logic [WORD_W-1:0] pktout_data;
    logic pktout_data_wr, pktout_data_valid, pktout_data_valid_wr, pktout_data_ready;
    logic [2:0] mux_err;

    modport slave (
        input  pgm2mux_data, lcm2mux_data, ssm2mux_data,
        input  pgm2mux_data_wr, lcm2mux_data_wr, ssm2mux_data_wr,
        input  pgm2mux_data_valid, lcm2mux_data_valid, ssm2mux_data_valid,
        input  pgm2mux_data_valid_wr, lcm2mux_data_valid_wr, ssm2mux_data_valid_wr,
        output mux2pgm_data_ready, mux2lcm_data_ready, mux2ssm_data_ready,
        output pktout_data, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr,
        input  pktout_data_ready,
        output mux_err
    );

    modport master (
        output pgm2mux_data, lcm2mux_data, ssm2mux_data,
        output pgm2mux_data_wr, lcm2mux_data_wr, ssm2mux_data_wr,
        output pgm2mux_data_valid, lcm2mux_data_valid, ssm2mux_data_valid,
        output pgm2mux_data_valid_wr, lcm2mux_data_valid_wr, ssm2mux_data_valid_wr,
        input  mux2pgm_data_ready, mux2lcm_data_ready, mux2ssm_data_ready,
        input  pktout_data, pktout_data_wr, pktout_data_valid, pktout_data_valid_wr,
        output pktout_data_ready,
        input  mux_err
    );
endinterface

// File: rtl/pkt_mux_fifo.sv
// Per-source packet buffer: data FIFO, packet-flag FIFO, registered ready and sticky overflow flag.
module pkt_mux_fifo
    import pkt_mux_pkg::*;
#(
    parameter int DATA_AW    = 8,
    parameter int VALID_AW   = 4,
    parameter int READY_FREE = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr,
    input  logic              valid,
    input  logic              valid_wr,
    input  logic              rd,
    input  logic              vld_rd,
    output logic [WORD_W-1:0] rd_data,
    output logic              vld_dout,
    output logic              vld_empty,
    output logic              ready,
    output logic              err
);
    localparam int DDEPTH = 1 << DATA_AW;
    localparam int VDEPTH = 1 << VALID_AW;

    logic [WORD_W-1:0] dmem [DDEPTH];
    logic              vmem [VDEPTH];
    logic [DATA_AW-1:0]  dwp, drp;
    logic [DATA_AW:0]    dcnt, dfree;
    logic [VALID_AW-1:0] vwp, vrp;
    logic [VALID_AW:0]   vcnt;
    logic dfull, vfull, dpush, dpop, vpush, vpop;

    assign dfull     = (dcnt == (DATA_AW+1)'(DDEPTH));
    assign vfull     = (vcnt == (VALID_AW+1)'(VDEPTH));
    assign dpop      = rd && (dcnt != '0);
    assign vpop      = vld_rd && (vcnt != '0);
    // A full FIFO still accepts a word in the same cycle it releases one.
    assign dpush     = wr && (!dfull || dpop);
    assign vpush     = valid_wr && (!vfull || vpop);
    assign dfree     = (DATA_AW+1)'(DDEPTH) - dcnt;
    assign vld_dout  = vmem[vrp];
    assign vld_empty = (vcnt == '0);

    always_ff @(posedge clk) begin
        if (dpush) dmem[dwp] <= wr_data;
        if (vpush) vmem[vwp] <= valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dwp <= '0; drp <= '0; dcnt <= '0;
            vwp <= '0; vrp <= '0; vcnt <= '0;
            rd_data <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (dpush) dwp <= dwp + DATA_AW'(1);
            if (vpush) vwp <= vwp + VALID_AW'(1);
            if (dpop) begin
                drp     <= drp + DATA_AW'(1);
                rd_data <= dmem[drp];
            end
            if (vpop) vrp <= vrp + VALID_AW'(1);
            dcnt  <= dcnt + (DATA_AW+1)'(dpush) - (DATA_AW+1)'(dpop);
            vcnt  <= vcnt + (VALID_AW+1)'(vpush) - (VALID_AW+1)'(vpop);
            if ((wr && !dpush) || (valid_wr && !vpush)) err <= 1'b1;
            ready <= (dfree >= (DATA_AW+1)'(READY_FREE)) && !vfull;
        end
    end
endmodule

// File: rtl/pkt_mux.sv
// Egress packet mux: merges PGM/LCM/SSM packet streams with a packet-level round-robin arbiter.
// Define MUX_LCM_PRIO_EN to give LCM strict priority over the PGM/SSM round-robin.
module pkt_mux
    import pkt_mux_pkg::*;
#(
    parameter int DATA_AW    = 8,
    parameter int VALID_AW   = 4,
    parameter int READY_FREE = 100
) (
    input  logic       clk,
    input  logic       rst,
    pkt_mux_if.slave   bus,
    output mux_state_t dbg_state
);
    logic [WORD_W-1:0] wr_data [3];
    logic [WORD_W-1:0] rd_data [3];
    logic [2:0] wr, vld, vld_wr, rd, vld_rd, vld_dout, vld_empty, ready, err, cand;

    mux_state_t        state;
    logic [1:0]        sel, rr_ptr, gnt_idx;
    logic              gnt_any, busy_pop;
    logic [WORD_W-1:0] cur_word, out_data;
    logic              out_wr, out_valid, out_vwr;

    assign wr_data = '{bus.pgm2mux_data, bus.lcm2mux_data, bus.ssm2mux_data};
    assign wr      = {bus.ssm2mux_data_wr, bus.lcm2mux_data_wr, bus.pgm2mux_data_wr};
    assign vld     = {bus.ssm2mux_data_valid, bus.lcm2mux_data_valid, bus.pgm2mux_data_valid};
    assign vld_wr  = {bus.ssm2mux_data_valid_wr, bus.lcm2mux_data_valid_wr, bus.pgm2mux_data_valid_wr};

    for (genvar i = 0; i < 3; i++) begin : g_src
        pkt_mux_fifo #(.DATA_AW(DATA_AW), .VALID_AW(VALID_AW), .READY_FREE(READY_FREE)) u_fifo (
            .clk(clk), .rst(rst),
            .wr_data(wr_data[i]), .wr(wr[i]), .valid(vld[i]), .valid_wr(vld_wr[i]),
            .rd(rd[i]), .vld_rd(vld_rd[i]),
            .rd_data(rd_data[i]), .vld_dout(vld_dout[i]), .vld_empty(vld_empty[i]),
            .ready(ready[i]), .err(err[i])
        );
    end

    // Discard-flagged packets need no downstream space, so they compete even without ready.
    assign cand     = ~vld_empty & ({3{bus.pktout_data_ready}} | ~vld_dout);
    assign cur_word = rd_data[sel];
    assign busy_pop = ((state == SEND) || (state == DROP)) && (cur_word[WORD_W-1 -: 2] != TAIL);

`ifdef MUX_LCM_PRIO_EN
    logic [1:0] rr_other;
    assign rr_other = (rr_ptr == PGM) ? SSM : PGM;

    always_comb begin
        gnt_any = 1'b1;
        gnt_idx = PGM;
        if (cand[LCM])         gnt_idx = LCM;
        else if (cand[rr_ptr]) gnt_idx = rr_ptr;
        else if (cand[rr_other]) gnt_idx = rr_other;
        else                   gnt_any = 1'b0;
    end
`else
    logic [1:0] ord [3];

    always_comb begin
        ord[0]  = rr_ptr;
        ord[1]  = next_src(rr_ptr);
        ord[2]  = next_src(ord[1]);
        gnt_any = 1'b0;
        gnt_idx = PGM;
        for (int k = 0; k < 3; k++) begin
            if (!gnt_any && cand[ord[k]]) begin
                gnt_any = 1'b1;
                gnt_idx = ord[k];
            end
        end
    end
`endif

    // The head word is fetched in the grant cycle so it reaches pktout two cycles later.
    always_comb begin
        rd     = '0;
        vld_rd = '0;
        if ((state == IDLE) && gnt_any) begin
            rd[gnt_idx]     = 1'b1;
            vld_rd[gnt_idx] = 1'b1;
        end
        if (busy_pop) rd[sel] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= PGM;
            rr_ptr    <= PGM;
            out_data  <= '0;
            out_wr    <= 1'b0;
            out_valid <= 1'b0;
            out_vwr   <= 1'b0;
        end else begin
            out_data  <= '0;
            out_wr    <= 1'b0;
            out_valid <= 1'b0;
            out_vwr   <= 1'b0;
            case (state)
                IDLE: if (gnt_any) begin
                    sel   <= gnt_idx;
                    state <= vld_dout[gnt_idx] ? SEND : DROP;
`ifdef MUX_LCM_PRIO_EN
                    if (gnt_idx != LCM) rr_ptr <= (gnt_idx == PGM) ? SSM : PGM;
`else
                    rr_ptr <= next_src(gnt_idx);
`endif
                end
                SEND: begin
                    out_data <= cur_word;
                    out_wr   <= 1'b1;
                    if (!busy_pop) begin
                        out_valid <= 1'b1;
                        out_vwr   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                DROP: if (!busy_pop) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.pktout_data          = out_data;
    assign bus.pktout_data_wr       = out_wr;
    assign bus.pktout_data_valid    = out_valid;
    assign bus.pktout_data_valid_wr = out_vwr;
    assign bus.mux2pgm_data_ready   = ready[PGM];
    assign bus.mux2lcm_data_ready   = ready[LCM];
    assign bus.mux2ssm_data_ready   = ready[SSM];
    assign bus.mux_err              = err;
    assign dbg_state                = state;
endmodule

// File: tb/tb_pkt_mux.sv
// Self-checking bench for pkt_mux: vector table of single-source packets plus multi-cycle corner sequences.
module tb_pkt_mux;
  import pkt_mux_pkg::*;

  localparam int W = 135; // {tail flag, 134-bit word}

  logic clk = 1'b0;
  logic rst = 1'b1;
  mux_state_t dbg_state;
  pkt_mux_if bus();

  pkt_mux u_dut (.clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state));

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;
  int out_words = 0;
  int cyc = 0;
  int last_tail_cyc = -1;
  int max_gap = 0;
  bit in_pkt = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend0[$], pend1[$], pend2[$];

  typedef struct {
    int src;
    int len;
    bit flag;
    int exp_words;
  } vec_t;

  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    failures++;
    $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Scoreboard: every emitted word is matched against the head of exp_q.
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (rst) begin
      in_pkt = 1'b0;
    end else if (bus.pktout_data_wr) begin
      out_words++;
      got = {bus.pktout_data_valid_wr, bus.pktout_data};
      if (exp_q.size() == 0) fail("unexpected_word", got, '0);
      else begin
        exp = exp_q.pop_front();
        check(got == exp, "out_word", got, exp);
      end
      if (!in_pkt && last_tail_cyc >= 0 && (cyc - last_tail_cyc - 1) > max_gap)
        max_gap = cyc - last_tail_cyc - 1;
      if (bus.pktout_data_valid_wr) begin
        check(bus.pktout_data_valid == 1'b1, "tail_valid", W'(bus.pktout_data_valid), W'(1));
        last_tail_cyc = cyc;
        in_pkt = 1'b0;
      end else begin
        in_pkt = 1'b1;
      end
    end else begin
      if (in_pkt) fail("bubble", W'(0), W'(1));
      if (bus.pktout_data_valid_wr) fail("stray_valid_wr", W'(1), W'(0));
    end
  end

  task automatic drive_src(input int s, input logic [WORD_W-1:0] d, input logic wr, input logic vwr, input logic flag);
    case (s)
      0: begin bus.pgm2mux_data = d; bus.pgm2mux_data_wr = wr; bus.pgm2mux_data_valid_wr = vwr; bus.pgm2mux_data_valid = flag; end
      1: begin bus.lcm2mux_data = d; bus.lcm2mux_data_wr = wr; bus.lcm2mux_data_valid_wr = vwr; bus.lcm2mux_data_valid = flag; end
      default: begin bus.ssm2mux_data = d; bus.ssm2mux_data_wr = wr; bus.ssm2mux_data_valid_wr = vwr; bus.ssm2mux_data_valid = flag; end
    endcase
  endtask

  task automatic push_pend(input int s, input logic [W-1:0] v);
    case (s)
      0: pend0.push_back(v);
      1: pend1.push_back(v);
      default: pend2.push_back(v);
    endcase
  endtask

  task automatic move_pend(input int s);
    case (s)
      0: while (pend0.size() > 0) exp_q.push_back(pend0.pop_front());
      1: while (pend1.size() > 0) exp_q.push_back(pend1.pop_front());
      default: while (pend2.size() > 0) exp_q.push_back(pend2.pop_front());
    endcase
  endtask

  // Starts and ends 1 time unit after a rising edge; tail and valid_wr share the last cycle.
  task automatic send_pkt(input int s, input int len, input bit flag);
    logic [1:0] tag;
    logic [WORD_W-1:0] w;
    for (int i = 0; i < len; i++) begin
      tag = (i == len - 1) ? TAIL : ((i == 0) ? HEAD : BODY);
      w = {tag, 4'(i), $urandom, $urandom, $urandom, $urandom};
      drive_src(s, w, 1'b1, (i == len - 1), flag);
      if (flag) push_pend(s, {(i == len - 1), w});
      @(posedge clk); #1;
    end
    drive_src(s, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_words(input int s, input int n);
    for (int i = 0; i < n; i++) begin
      drive_src(s, {BODY, 4'(i), $urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0);
      @(posedge clk); #1;
    end
    drive_src(s, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    repeat (12) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      fail("drain_timeout", W'(exp_q.size()), W'(0));
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete(); pend0.delete(); pend1.delete(); pend2.delete();
    repeat (3) @(posedge clk);
    #1;
    check(bus.pktout_data_wr == 1'b0 && bus.pktout_data_valid_wr == 1'b0 && bus.pktout_data == '0,
          "reset_pktout", {bus.pktout_data_valid_wr, bus.pktout_data}, '0);
    check({bus.mux2ssm_data_ready, bus.mux2lcm_data_ready, bus.mux2pgm_data_ready} == 3'b000,
          "reset_ready_low", W'({bus.mux2ssm_data_ready, bus.mux2lcm_data_ready, bus.mux2pgm_data_ready}), W'(0));
    check(bus.mux_err == 3'b000, "reset_err", W'(bus.mux_err), W'(0));
    check(dbg_state == IDLE, "reset_state", W'(dbg_state), W'(IDLE));
    rst = 1'b0;
    @(posedge clk); #1;
    check({bus.mux2ssm_data_ready, bus.mux2lcm_data_ready, bus.mux2pgm_data_ready} == 3'b111,
          "ready_after_reset", W'({bus.mux2ssm_data_ready, bus.mux2lcm_data_ready, bus.mux2pgm_data_ready}), W'(7));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vec_t vecs[8];
    int base;
    int n;

    vecs[0] = '{0, 4, 1'b1, 4};   // plain PGM packet: tags 01,11,11,10
    vecs[1] = '{1, 3, 1'b0, 0};   // LCM discard
    vecs[2] = '{2, 5, 1'b1, 5};   // SSM forwarded after the discard
    vecs[3] = '{1, 2, 1'b1, 2};   // LCM FIFO left empty by the discard
    vecs[4] = '{2, 1, 1'b1, 1};   // single-word packet
    vecs[5] = '{0, 6, 1'b0, 0};
    vecs[6] = '{0, 96, 1'b1, 96}; // largest packet
    vecs[7] = '{1, 7, 1'b1, 7};

    drive_src(0, '0, 1'b0, 1'b0, 1'b0);
    drive_src(1, '0, 1'b0, 1'b0, 1'b0);
    drive_src(2, '0, 1'b0, 1'b0, 1'b0);
    bus.pktout_data_ready = 1'b1;
    do_reset();

    for (int v = 0; v < 8; v++) begin
      base = out_words;
      send_pkt(vecs[v].src, vecs[v].len, vecs[v].flag);
      move_pend(vecs[v].src);
      drain(400);
      check(out_words - base == vecs[v].exp_words, "vec_word_count", W'(out_words - base), W'(vecs[v].exp_words));
    end

    // Three pending packets held back by pktout_data_ready=0, then released.
    do_reset();
    bus.pktout_data_ready = 1'b0;
    base = out_words;
    send_pkt(0, 2, 1'b1);
    send_pkt(1, 2, 1'b1);
    send_pkt(2, 2, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check(out_words == base, "no_strobe_when_not_ready", W'(out_words - base), W'(0));
`ifdef MUX_LCM_PRIO_EN
    move_pend(1); move_pend(0); move_pend(2);
`else
    move_pend(0); move_pend(1); move_pend(2);
`endif
    max_gap = 0;
    last_tail_cyc = -1;
    bus.pktout_data_ready = 1'b1;
    drain(200);
    check(out_words - base == 6, "rr_word_count", W'(out_words - base), W'(6));
    check(max_gap <= 2, "back_to_back_gap", W'(max_gap), W'(2));

    // Downstream ready drops mid-packet; the packet must still complete.
    base = out_words;
    send_pkt(0, 8, 1'b1);
    move_pend(0);
    n = 0;
    while (out_words == base && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    bus.pktout_data_ready = 1'b0;
    drain(100);
    check(out_words - base == 8, "ready_drop_midpkt", W'(out_words - base), W'(8));
    bus.pktout_data_ready = 1'b1;

    // Ready threshold and overflow on PGM.
    do_reset();
    push_words(0, 156);
    repeat (2) @(posedge clk);
    #1;
    check(bus.mux2pgm_data_ready == 1'b1, "ready_at_free_100", W'(bus.mux2pgm_data_ready), W'(1));
    push_words(0, 1);
    repeat (2) @(posedge clk);
    #1;
    check(bus.mux2pgm_data_ready == 1'b0, "ready_at_free_99", W'(bus.mux2pgm_data_ready), W'(0));
    check(bus.mux2lcm_data_ready == 1'b1, "lcm_ready_unaffected", W'(bus.mux2lcm_data_ready), W'(1));
    push_words(0, 99);
    repeat (2) @(posedge clk);
    #1;
    check(bus.mux_err == 3'b000, "no_err_at_256", W'(bus.mux_err), W'(0));
    push_words(0, 1);
    repeat (2) @(posedge clk);
    #1;
    check(bus.mux_err == 3'b001, "err_at_257", W'(bus.mux_err), W'(1));
    repeat (3) @(posedge clk);
    #1;
    check(bus.mux_err == 3'b001, "err_sticky", W'(bus.mux_err), W'(1));

    // Reset during word 2 of a 5-word send.
    do_reset();
    base = out_words;
    send_pkt(0, 5, 1'b1);
    move_pend(0);
    n = 0;
    while (out_words < base + 2 && n < 60) begin
      @(negedge clk); #1;
      n++;
    end
    check(out_words == base + 2, "reached_word2", W'(out_words - base), W'(2));
    rst = 1'b1;
    @(posedge clk); #1;
    check(bus.pktout_data_wr == 1'b0 && bus.pktout_data_valid_wr == 1'b0 && bus.pktout_data == '0,
          "rst_truncates", {bus.pktout_data_valid_wr, bus.pktout_data}, '0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base = out_words;
    repeat (10) @(posedge clk);
    #1;
    check(out_words == base, "no_tail_after_rst", W'(out_words - base), W'(0));
    send_pkt(0, 3, 1'b1);
    move_pend(0);
    drain(100);
    check(out_words - base == 3, "pgm_flushed", W'(out_words - base), W'(3));

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule
